// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-I integer core with one shared req/ack memory port.
// Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB as needed.
// Illegal instructions, misaligned addresses and bus timeouts park the core
// in TRAP until reset.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] current_pc,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        instr_retired,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_ADD = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;

  // True for every opcode/funct pair the core implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_ADD, F_ADDU, F_SUB,
          F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d, wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic        retired_q, retired_d;
  logic [31:0] rf_q [32];

  logic        rf_we_s, mem_req_s, mem_we_s, timeout_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] rf_wdata_s, mem_addr_s, alu_res_s, ea_s, simm_s, zimm_s;
  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;

  assign opcode_s  = ir_q[31:26];
  assign rs_s      = ir_q[25:21];
  assign rt_s      = ir_q[20:16];
  assign rd_s      = ir_q[15:11];
  assign shamt_s   = ir_q[10:6];
  assign funct_s   = ir_q[5:0];
  assign simm_s    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm_s    = {16'h0000, ir_q[15:0]};
  assign ea_s      = a_q + simm_s;
  // The counter holds waits already seen; this cycle's wait would be number TIMEOUT.
  assign timeout_s = (TIMEOUT != 32'd0) && ((wait_q + 32'd1) == TIMEOUT);

  // ALU for R-type and immediate arithmetic; results land in ALUOut in EXEC.
  always_comb begin
    alu_res_s = 32'd0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_ADD, F_ADDU: alu_res_s = a_q + b_q;
          F_SUB, F_SUBU: alu_res_s = a_q - b_q;
          F_AND:  alu_res_s = a_q & b_q;
          F_OR:   alu_res_s = a_q | b_q;
          F_XOR:  alu_res_s = a_q ^ b_q;
          F_NOR:  alu_res_s = ~(a_q | b_q);
          F_SLT:  alu_res_s = {31'd0, $signed(a_q) < $signed(b_q)};
          F_SLTU: alu_res_s = {31'd0, a_q < b_q};
          F_SLL:  alu_res_s = b_q << shamt_s;
          F_SRL:  alu_res_s = b_q >> shamt_s;
          F_SRA:  alu_res_s = $signed(b_q) >>> shamt_s;
          F_SLLV: alu_res_s = b_q << a_q[4:0];
          F_SRLV: alu_res_s = b_q >> a_q[4:0];
          F_SRAV: alu_res_s = $signed(b_q) >>> a_q[4:0];
          default: alu_res_s = 32'd0;
        endcase
      end
      OP_ADDI, OP_ADDIU: alu_res_s = a_q + simm_s;
      OP_SLTI: alu_res_s = {31'd0, $signed(a_q) < $signed(simm_s)};
      OP_ANDI: alu_res_s = a_q & zimm_s;
      OP_ORI:  alu_res_s = a_q | zimm_s;
      OP_XORI: alu_res_s = a_q ^ zimm_s;
      OP_LUI:  alu_res_s = {ir_q[15:0], 16'h0000};
      default: alu_res_s = 32'd0;
    endcase
  end

  // Next-state, datapath register updates and memory/regfile controls per state.
  always_comb begin
    state_d = state_q;   pc_d = pc_q;     ir_d = ir_q;   a_d = a_q;   b_d = b_q;
    aluout_d = aluout_q; mdr_d = mdr_q;   cause_d = cause_q;
    wait_d = 32'd0;      retired_d = 1'b0;
    rf_we_s = 1'b0;      rf_waddr_s = 5'd0; rf_wdata_s = 32'd0;
    mem_req_s = 1'b0;    mem_we_s = 1'b0;   mem_addr_s = pc_q;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_TRAP; cause_d = 2'd3;
        end else begin
          mem_req_s = 1'b1;
          if (mem_ack) begin
            ir_d = mem_rdata; pc_d = pc_q + 32'd4; state_d = S_DECODE;
          end else if (timeout_s) begin
            state_d = S_TRAP; cause_d = 2'd2;
          end else begin
            wait_d = wait_q + 32'd1;
          end
        end
      end
      S_DECODE: begin
        if (!is_legal(opcode_s, funct_s)) begin
          state_d = S_TRAP; cause_d = 2'd1;
        end else begin
          a_d = rf_q[rs_s]; b_d = rf_q[rt_s];
          aluout_d = pc_q + {simm_s[29:0], 2'b00};
          if (opcode_s == OP_J || opcode_s == OP_JAL) begin
            pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH; retired_d = 1'b1;
            // pc_q is already the incremented PC, i.e. the link address.
            rf_we_s = (opcode_s == OP_JAL); rf_waddr_s = 5'd31; rf_wdata_s = pc_q;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OP_LW, OP_SW: begin
            aluout_d = ea_s;
            if (ea_s[1:0] != 2'b00) begin
              state_d = S_TRAP; cause_d = 2'd3;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (opcode_s == OP_BEQ)) begin
              pc_d = aluout_q;
            end else begin
              pc_d = pc_q;
            end
            state_d = S_FETCH; retired_d = 1'b1;
          end
          default: begin
            if (opcode_s == OP_RTYPE && funct_s == F_JR) begin
              pc_d = a_q; state_d = S_FETCH; retired_d = 1'b1;
            end else begin
              aluout_d = alu_res_s; state_d = S_WB;
            end
          end
        endcase
      end
      S_MEM: begin
        mem_req_s = 1'b1; mem_addr_s = aluout_q; mem_we_s = (opcode_s == OP_SW);
        if (mem_ack) begin
          if (opcode_s == OP_SW) begin
            state_d = S_FETCH; retired_d = 1'b1;
          end else begin
            mdr_d = mem_rdata; state_d = S_WB;
          end
        end else if (timeout_s) begin
          state_d = S_TRAP; cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WB: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
        rf_wdata_s = (opcode_s == OP_LW) ? mdr_q : aluout_q;
        state_d = S_FETCH; retired_d = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // FSM and architectural/datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH; pc_q <= RESET_PC; ir_q <= 32'd0; a_q <= 32'd0; b_q <= 32'd0;
      aluout_q <= 32'd0;  mdr_q <= 32'd0;   wait_q <= 32'd0; cause_q <= 2'd0; retired_q <= 1'b0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d;
      aluout_q <= aluout_d; mdr_q <= mdr_d; wait_q <= wait_d; cause_q <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Register file write port; $0 stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
      rf_q[rf_waddr_s] <= rf_wdata_s;
    end
  end

  // Requests drop asynchronously while reset is held.
  assign mem_req        = reset & mem_req_s;
  assign mem_we         = reset & mem_we_s;
  assign mem_addr       = mem_addr_s;
  assign mem_wdata      = b_q;
  assign current_pc     = pc_q;
  assign alu_result_out = aluout_q;
  assign mem_data_out   = mdr_q;
  assign instr_retired  = retired_q;
  assign halted         = (state_q == S_TRAP);
  assign trap_cause     = cause_q;

endmodule
